// File: rtl/interrupt_request_latch_8.sv
// 8-line interrupt request latch: captures edge/level requests into a pending
// vector and issues the lowest-index unmasked one through a valid/ack handshake.

module irl_bit_cell #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic Clk_In,
  input  logic Reset_In,
  input  logic req_i,
  input  logic clear_i,
  output logic pending_o,
  output logic ovf_o
);
  logic prev_q, pend_q, pend_d, cap;

  // Reset loads prev from the line so a request already high yields no edge.
  assign cap    = EDGE_MODE ? (req_i & ~prev_q) : req_i;
  assign pend_d = cap | (pend_q & ~clear_i);
  assign ovf_o  = EDGE_MODE ? (cap & pend_q & ~clear_i) : 1'b0;

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      prev_q <= req_i;
      pend_q <= 1'b0;
    end else begin
      prev_q <= req_i;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;
endmodule

module interrupt_request_latch_8 #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic       Clk_In,
  input  logic       Reset_In,
  input  logic       Enable_In,
  input  logic [7:0] Req_In,
  input  logic [7:0] Mask_In,
  input  logic       Ack_In,
  output logic [7:0] Pending_Out,
  output logic       Valid_Out,
  output logic [2:0] Index_Out,
  output logic       Overflow_Out
);
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d, winner;
  logic       ovf_q, ovf_d;
  logic [7:0] sel, clear, ovf_bit;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign clear[i] = (state_q == ISSUE) & Ack_In & (idx_q == 3'(i));
    irl_bit_cell #(.EDGE_MODE(EDGE_MODE)) u_cell (
      .Clk_In   (Clk_In),
      .Reset_In (Reset_In),
      .req_i    (Req_In[i]),
      .clear_i  (clear[i]),
      .pending_o(Pending_Out[i]),
      .ovf_o    (ovf_bit[i])
    );
  end

  assign sel = Pending_Out & ~Mask_In;

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (sel[i]) winner = 3'(i);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q | (|ovf_bit);
    case (state_q)
      IDLE: if (Enable_In && (|sel)) begin
        idx_d   = winner;
        state_d = ISSUE;
      end
      ISSUE: if (Ack_In) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Valid_Out    = (state_q == ISSUE);
  assign Index_Out    = idx_q;
  assign Overflow_Out = ovf_q;
endmodule
